// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: runs one req/ack bus transaction per load/store and stalls MEM until it completes.
// Optional bus timeout (BusErr_M) is built only when MEMACC_TIMEOUT_EN is defined.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead_M,
  input  logic        MemWrite_M,
  input  logic        kill_M,
  input  logic [1:0]  SizeOp_M,
  input  logic [31:0] Addr_M,
  input  logic [31:0] StoreData_M,
  output logic        stall_M,
  output logic [31:0] LoadOut_M,
  output logic [1:0]  ByteAddr_M,
  output logic        AdEL_M,
  output logic        AdES_M,
  output logic        BusErr_M,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] load_out_q, load_out_d;
  logic [1:0]  byte_addr_q, byte_addr_d;
  logic        bus_err_q, bus_err_d;

  logic        misaligned;
  logic        access;
  logic        timeout_hit;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    misaligned = 1'b0;
    be_c       = 4'b1111;
    wdata_c    = StoreData_M;
    case (SizeOp_M)
      2'b01: begin
        misaligned = Addr_M[0];
        be_c       = 4'b0011 << Addr_M[1:0];
        wdata_c    = {2{StoreData_M[15:0]}};
      end
      2'b10: begin
        be_c    = 4'b0001 << Addr_M[1:0];
        wdata_c = {4{StoreData_M[7:0]}};
      end
      default: misaligned = |Addr_M[1:0];
    endcase
  end

  assign access  = (MemRead_M | MemWrite_M) & ~kill_M & ~misaligned;
  assign AdEL_M  = MemRead_M & misaligned & ~kill_M;
  assign AdES_M  = MemWrite_M & misaligned & ~kill_M;
  assign stall_M = access & (state_q != DONE);

`ifdef MEMACC_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Holding the counter at zero while idle is what clears it on entry to BUSY.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == IDLE)
      tmo_cnt_d = '0;
    else if (state_q == BUSY && !bus_ack)
      tmo_cnt_d = tmo_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) tmo_cnt_q <= '0;
    else        tmo_cnt_q <= tmo_cnt_d;
  end

  assign timeout_hit = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    load_out_d  = load_out_q;
    byte_addr_d = byte_addr_q;
    bus_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          state_d     = BUSY;
          bus_req_d   = 1'b1;
          bus_we_d    = MemWrite_M;
          bus_addr_d  = {Addr_M[31:2], 2'b00};
          bus_be_d    = be_c;
          bus_wdata_d = wdata_c;
        end
      end
      BUSY: begin
        // Ack wins over a timeout landing in the same cycle; kill_M is deliberately not looked at.
        if (bus_ack) begin
          state_d     = DONE;
          bus_req_d   = 1'b0;
          load_out_d  = bus_we_q ? 32'h0 : bus_rdata;
          byte_addr_d = Addr_M[1:0];
        end else if (timeout_hit) begin
          state_d    = DONE;
          bus_req_d  = 1'b0;
          load_out_d = 32'h0;
          bus_err_d  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments; reset is synchronous, so it is only seen on a clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      load_out_q  <= '0;
      byte_addr_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      load_out_q  <= load_out_d;
      byte_addr_q <= byte_addr_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_be     = bus_be_q;
  assign bus_wdata  = bus_wdata_q;
  assign LoadOut_M  = load_out_q;
  assign ByteAddr_M = byte_addr_q;
  assign BusErr_M   = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a transaction-level model checked every cycle plus hand-computed literals.
// Timeout scenarios run only when MEMACC_TIMEOUT_EN is defined.
module tb_mem_access_unit;

  localparam int TB_TMO = 4;
`ifdef MEMACC_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemRead_M, MemWrite_M, kill_M;
  logic [1:0]  SizeOp_M;
  logic [31:0] Addr_M, StoreData_M;
  logic        stall_M;
  logic [31:0] LoadOut_M;
  logic [1:0]  ByteAddr_M;
  logic        AdEL_M, AdES_M, BusErr_M;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  mem_access_unit #(.TIMEOUT_CYCLES(TB_TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .MemRead_M(MemRead_M), .MemWrite_M(MemWrite_M), .kill_M(kill_M),
    .SizeOp_M(SizeOp_M), .Addr_M(Addr_M), .StoreData_M(StoreData_M),
    .stall_M(stall_M), .LoadOut_M(LoadOut_M), .ByteAddr_M(ByteAddr_M),
    .AdEL_M(AdEL_M), .AdES_M(AdES_M), .BusErr_M(BusErr_M),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: an access is outstanding from issue until ack/timeout, then is delivered for one cycle.
  function automatic bit f_misaligned(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'b10) return 1'b0;
    if (size == 2'b01) return (addr % 2) != 0;
    return (addr % 4) != 0;
  endfunction

  function automatic logic [3:0] f_be(input logic [1:0] size, input logic [31:0] addr);
    int off = int'(addr % 4);
    if (size == 2'b10) return 4'(1 << off);
    if (size == 2'b01) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] f_wdata(input logic [1:0] size, input logic [31:0] d);
    if (size == 2'b10) return (d % 256) * 32'h0101_0101;
    if (size == 2'b01) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic bit f_access();
    return (MemRead_M || MemWrite_M) && !kill_M && !f_misaligned(SizeOp_M, Addr_M);
  endfunction

  bit          model_valid = 1'b0;
  bit          m_pending, m_complete, m_err;
  int          m_wait;
  logic        m_req, m_we;
  logic [31:0] m_addr, m_wdata, m_load;
  logic [3:0]  m_be;
  logic [1:0]  m_ba;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pending = 0; m_complete = 0; m_err = 0; m_wait = 0;
      m_req = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_load = 0; m_be = 0; m_ba = 0;
      model_valid = 1'b1;
    end else begin
      m_err = 0;
      if (m_complete) begin
        m_complete = 0;
      end else if (m_pending) begin
        if (bus_ack) begin
          m_pending = 0; m_complete = 1; m_req = 0;
          m_load = m_we ? 32'h0 : bus_rdata;
          m_ba = Addr_M[1:0];
        end else if (TMO_EN && m_wait == TB_TMO - 1) begin
          m_pending = 0; m_complete = 1; m_req = 0; m_load = 32'h0; m_err = 1;
        end else begin
          m_wait++;
        end
      end else if (f_access()) begin
        m_pending = 1; m_wait = 0; m_req = 1; m_we = MemWrite_M;
        m_addr  = Addr_M - (Addr_M % 4);
        m_be    = f_be(SizeOp_M, Addr_M);
        m_wdata = f_wdata(SizeOp_M, StoreData_M);
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("stall_M",    32'(stall_M),    32'(f_access() && !m_complete));
      check("AdEL_M",     32'(AdEL_M),     32'(MemRead_M && !kill_M && f_misaligned(SizeOp_M, Addr_M)));
      check("AdES_M",     32'(AdES_M),     32'(MemWrite_M && !kill_M && f_misaligned(SizeOp_M, Addr_M)));
      check("BusErr_M",   32'(BusErr_M),   32'(m_err));
      check("bus_req",    32'(bus_req),    32'(m_req));
      check("bus_we",     32'(bus_we),     32'(m_we));
      check("bus_addr",   bus_addr,        m_addr);
      check("bus_be",     32'(bus_be),     32'(m_be));
      check("bus_wdata",  bus_wdata,       m_wdata);
      check("LoadOut_M",  LoadOut_M,       m_load);
      check("ByteAddr_M", 32'(ByteAddr_M), 32'(m_ba));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; MemRead_M = 0; MemWrite_M = 0; kill_M = 0;
    SizeOp_M = 2'b00; Addr_M = 0; StoreData_M = 0; bus_ack = 0; bus_rdata = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("rst_bus_req", 32'(bus_req), 32'h0);
    check("rst_stall", 32'(stall_M), 32'h0);
    check("rst_loadout", LoadOut_M, 32'h0);

    // Word load at 0x100, ack in the second BUSY cycle
    MemRead_M = 1; SizeOp_M = 2'b00; Addr_M = 32'h100;
    #1 check("t1_stall_idle", 32'(stall_M), 32'h1);
    tick();
    check("t1_req", 32'(bus_req), 32'h1);
    check("t1_addr", bus_addr, 32'h100);
    check("t1_be", 32'(bus_be), 32'hF);
    check("t1_we", 32'(bus_we), 32'h0);
    tick();
    bus_ack = 1; bus_rdata = 32'hDEADBEEF;
    #1 check("t1_stall_busy2", 32'(stall_M), 32'h1);
    tick();
    #1;
    check("t1_stall_done", 32'(stall_M), 32'h0);
    check("t1_loadout", LoadOut_M, 32'hDEADBEEF);
    check("t1_byteaddr", 32'(ByteAddr_M), 32'h0);
    MemRead_M = 0;
    tick();
    tick();
    bus_ack = 0; bus_rdata = 0;

    // Byte store at 0x203
    MemWrite_M = 1; SizeOp_M = 2'b10; Addr_M = 32'h203; StoreData_M = 32'h12345678;
    tick();
    check("t2_addr", bus_addr, 32'h200);
    check("t2_be", 32'(bus_be), 32'h8);
    check("t2_wdata", bus_wdata, 32'h78787878);
    check("t2_we", 32'(bus_we), 32'h1);
    bus_ack = 1; bus_rdata = 32'hFFFFFFFF;
    tick();
    #1;
    check("t2_loadout", LoadOut_M, 32'h0);
    check("t2_byteaddr", 32'(ByteAddr_M), 32'h3);
    MemWrite_M = 0; bus_ack = 0;
    tick();

    // Misaligned half load, word store, reserved-size load
    MemRead_M = 1; SizeOp_M = 2'b01; Addr_M = 32'h101;
    #1;
    check("t3_adel", 32'(AdEL_M), 32'h1);
    check("t3_stall", 32'(stall_M), 32'h0);
    tick();
    check("t3_req", 32'(bus_req), 32'h0);
    MemRead_M = 0; MemWrite_M = 1; SizeOp_M = 2'b00; Addr_M = 32'h102;
    #1;
    check("t3_ades", 32'(AdES_M), 32'h1);
    check("t3_adel_store", 32'(AdEL_M), 32'h0);
    tick();
    check("t3_req2", 32'(bus_req), 32'h0);
    MemWrite_M = 0; MemRead_M = 1; SizeOp_M = 2'b11; Addr_M = 32'h201;
    #1 check("t3_adel_rsvd", 32'(AdEL_M), 32'h1);
    tick();
    MemRead_M = 0;

    // kill_M in IDLE blocks the access; kill_M during BUSY does not abort it
    MemWrite_M = 1; kill_M = 1; SizeOp_M = 2'b00; Addr_M = 32'h300; StoreData_M = 32'hA5A5A5A5;
    #1 check("t4_kill_stall", 32'(stall_M), 32'h0);
    tick();
    check("t4_kill_req", 32'(bus_req), 32'h0);
    MemWrite_M = 0; kill_M = 0; MemRead_M = 1; SizeOp_M = 2'b01; Addr_M = 32'h306;
    tick();
    check("t4_req_busy", 32'(bus_req), 32'h1);
    kill_M = 1;
    tick();
    check("t4_req_killed", 32'(bus_req), 32'h1);
    bus_ack = 1; bus_rdata = 32'h5555AAAA;
    tick();
    #1;
    check("t4_loadout", LoadOut_M, 32'h5555AAAA);
    check("t4_byteaddr", 32'(ByteAddr_M), 32'h2);
    kill_M = 0; MemRead_M = 0; bus_ack = 0;
    tick();

    // Reset in the middle of a transaction, then a normal load
    MemRead_M = 1; SizeOp_M = 2'b01; Addr_M = 32'h106;
    tick();
    check("t5_req_busy", 32'(bus_req), 32'h1);
    MemRead_M = 0; rst_n = 0;
    tick();
    #1;
    check("t5_rst_req", 32'(bus_req), 32'h0);
    check("t5_rst_stall", 32'(stall_M), 32'h0);
    check("t5_rst_loadout", LoadOut_M, 32'h0);
    check("t5_rst_addr", bus_addr, 32'h0);
    rst_n = 1; MemRead_M = 1; SizeOp_M = 2'b00; Addr_M = 32'h108;
    tick();
    bus_ack = 1; bus_rdata = 32'hCAFEF00D;
    tick();
    #1;
    check("t5_loadout", LoadOut_M, 32'hCAFEF00D);
    check("t5_stall_done", 32'(stall_M), 32'h0);
    MemRead_M = 0; bus_ack = 0;
    tick();

`ifdef MEMACC_TIMEOUT_EN
    // No ack: timeout after four BUSY cycles
    MemRead_M = 1; SizeOp_M = 2'b00; Addr_M = 32'h400;
    repeat (4) tick();
    #1;
    check("t6_no_err_yet", 32'(BusErr_M), 32'h0);
    check("t6_req_held", 32'(bus_req), 32'h1);
    tick();
    #1;
    check("t6_buserr", 32'(BusErr_M), 32'h1);
    check("t6_loadout", LoadOut_M, 32'h0);
    check("t6_stall", 32'(stall_M), 32'h0);
    MemRead_M = 0;
    tick();
    check("t6_err_pulse", 32'(BusErr_M), 32'h0);

    // Ack on the fourth BUSY cycle beats the timeout
    MemRead_M = 1; Addr_M = 32'h404;
    repeat (4) tick();
    bus_ack = 1; bus_rdata = 32'h0BADF00D;
    tick();
    #1;
    check("t7_no_err", 32'(BusErr_M), 32'h0);
    check("t7_loadout", LoadOut_M, 32'h0BADF00D);
    MemRead_M = 0; bus_ack = 0;
    tick();
`endif

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
